// File: rtl/mdu_seq.sv
// Iterative MULTU/MULT/DIVU/DIV unit: one shift-add or restoring shift-subtract
// step per clock through a single 33-bit adder with carry-in, result into hi/lo.
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic                 accept, step, fin;
  logic                 is_div, neg_res, neg_rem, dz_q;
  logic [WIDTH-1:0]     upper, lower, dvs, a_orig;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       add_a, add_b;
  logic                 cin;
  logic [WIDTH+1:0]     sum;
  logic [2*WIDTH-1:0]   prod_f;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    accept = (state == IDLE) && start;
    step   = (state == CALC);
    fin    = (state == FIN);
    busy   = (state != IDLE);
  end

  // Signed ops use magnitudes; 0x80000000 negates to itself, read as 2^31.
  always_comb begin
    a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
    b_mag = (op[0] && b[WIDTH-1]) ? -b : b;
  end

  // Divide: shifted 33-bit remainder minus divisor (carry=1 means no borrow).
  always_comb begin
    if (is_div) begin
      add_a = {upper, lower[WIDTH-1]};
      add_b = ~{1'b0, dvs};
      cin   = 1'b1;
    end else begin
      add_a = {1'b0, upper};
      add_b = lower[0] ? {1'b0, dvs} : '0;
      cin   = 1'b0;
    end
    sum    = {1'b0, add_a} + {1'b0, add_b} + (WIDTH+2)'(cin);
    prod_f = neg_res ? -{upper, lower} : {upper, lower};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz_q     <= 1'b0;
      upper    <= '0;
      lower    <= '0;
      dvs      <= '0;
      a_orig   <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        is_div   <= op[1];
        neg_res  <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem  <= op[0] & a[WIDTH-1];
        dz_q     <= op[1] & (b == '0);
        a_orig   <= a;
        upper    <= '0;
        lower    <= op[1] ? a_mag : b_mag;
        dvs      <= op[1] ? b_mag : a_mag;
        cnt      <= CW'(WIDTH);
        div_zero <= 1'b0;
      end else if (step) begin
        cnt <= cnt - CW'(1);
        if (is_div) begin
          if (sum[WIDTH+1]) begin
            upper <= sum[WIDTH-1:0];
            lower <= {lower[WIDTH-2:0], 1'b1};
          end else begin
            upper <= {upper[WIDTH-2:0], lower[WIDTH-1]};
            lower <= {lower[WIDTH-2:0], 1'b0};
          end
        end else begin
          upper <= sum[WIDTH:1];
          lower <= {sum[0], lower[WIDTH-1:1]};
        end
      end else if (fin) begin
        done <= 1'b1;
        if (dz_q) begin
          hi       <= a_orig;
          lo       <= '1;
          div_zero <= 1'b1;
        end else if (is_div) begin
          hi <= neg_rem ? -upper : upper;
          lo <= neg_res ? -lower : lower;
        end else begin
          {hi, lo} <= prod_f;
        end
      end
    end
  end
endmodule

// File: tb/tb_mdu_seq.sv
// Randomized and directed bench for mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
  logic        clk = 1'b0;
  logic        rst, start, busy, done, div_zero;
  logic [1:0]  op;
  logic [31:0] a, b, hi, lo;
  int          errors = 0, checks = 0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return {32'b0, x} * {32'b0, y};
      2'd1: return 64'(sx * sy);
      2'd2: if (y == 0) return {x, 32'hFFFFFFFF}; else return {x % y, x / y};
      default: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Issues one op; lat counts edges after the start edge until done is seen.
  task automatic do_op(input bit now, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output logic [31:0] h, output logic [31:0] l,
                       output logic dz, output int bcnt, output bit held);
    logic [31:0] ph, pl;
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    ph = hi; pl = lo; held = 1'b1; bcnt = 0;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      if (hi !== ph || lo !== pl) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    h = hi; l = lo; dz = div_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_zero}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    rst = 1'b0;
  endtask

  task automatic test_multu_max();
    int lat, bc; logic [31:0] h, l; logic dz; bit held;
    do_op(0, 2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, h, l, dz, bc, held);
    checks++; if (lat !== 33) begin errors++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    checks++; if ({h, l} !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max got=%h exp=fffffffe00000001", {h, l}); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc; logic [31:0] h, l; logic dz; bit held;
    do_op(0, 2'd1, 32'hFFFFFFFD, 32'd7, lat, h, l, dz, bc, held);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFEB) begin errors++; $display("FAIL mult_neg got=%h exp=ffffffffffffffeb", {h, l}); end
    do_op(1, 2'd2, 32'd100, 32'd7, lat, h, l, dz, bc, held);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    checks++; if ({h, l} !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7 got=%h exp=%h", {h, l}, {32'd2, 32'd14}); end
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL b2b_hold got=%b exp=1", held); end
  endtask

  task automatic test_div_signed();
    int lat, bc; logic [31:0] h, l; logic dz; bit held;
    do_op(0, 2'd3, 32'hFFFFFFF9, 32'd2, lat, h, l, dz, bc, held);
    checks++; if ({h, l} !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_m7_2 got=%h exp=fffffffffffffffd", {h, l}); end
    do_op(0, 2'd3, 32'h80000000, 32'hFFFFFFFF, lat, h, l, dz, bc, held);
    checks++; if ({h, l} !== 64'h00000000_80000000) begin errors++; $display("FAIL div_ovf got=%h exp=0000000080000000", {h, l}); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_ovf_dz got=%b exp=0", dz); end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [31:0] h, l; logic dz; bit held;
    do_op(0, 2'd2, 32'h12345678, 32'd0, lat, h, l, dz, bc, held);
    checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency got=%0d exp=33", lat); end
    checks++; if ({h, l, dz} !== {32'h12345678, 32'hFFFFFFFF, 1'b1}) begin errors++; $display("FAIL dz_result got=%h/%h/%b exp=12345678/ffffffff/1", h, l, dz); end
    @(negedge clk);
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_hold got=%b exp=1", div_zero); end
    start = 1'b1; op = 2'd0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", div_zero); end
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    checks++; if (lo !== 32'd1) begin errors++; $display("FAIL dz_next_op got=%h exp=1", lo); end
  endtask

  task automatic test_ignore_busy_start();
    int dones = 0, at = -1; logic [31:0] h = '0, l = '0;
    @(negedge clk);
    start = 1'b1; op = 2'd0; a = 32'd5; b = 32'd6;
    @(negedge clk);
    for (int i = 0; i < 45; i++) begin
      if (done) begin dones++; at = i; h = hi; l = lo; end
      if (i == 10) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      else start = 1'b0;
      @(negedge clk);
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (at !== 33) begin errors++; $display("FAIL ignore_latency got=%0d exp=33", at); end
    checks++; if ({h, l} !== {32'd0, 32'd30}) begin errors++; $display("FAIL ignore_result got=%h exp=%h", {h, l}, {32'd0, 32'd30}); end
  endtask

  task automatic test_reset_abort();
    int dones = 0, lat, bc; logic [31:0] h, l; logic dz; bit held;
    @(negedge clk);
    start = 1'b1; op = 2'd3; a = 32'hFFFFFF00; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL abort_flags got=%b exp=00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL abort_hilo got=%h exp=0", {hi, lo}); end
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", dones); end
    do_op(0, 2'd0, 32'd2, 32'd3, lat, h, l, dz, bc, held);
    checks++; if (lat !== 33 || {h, l} !== 64'd6) begin errors++; $display("FAIL abort_next got=%0d/%h exp=33/6", lat, {h, l}); end
  endtask

  task automatic test_random();
    int lat, bc; logic [31:0] h, l, x, y; logic [1:0] o; logic dz; bit held; logic [63:0] exp;
    for (int n = 0; n < 24; n++) begin
      o = 2'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: x = 32'h80000000;
        2: y = 32'($urandom_range(1, 9));
        3: y = 32'hFFFFFFFF;
        default: ;
      endcase
      exp = model(o, x, y);
      do_op(($urandom_range(0, 1) == 1), o, x, y, lat, h, l, dz, bc, held);
      checks++; if ({h, l} !== exp) begin errors++; $display("FAIL rand_result op=%0d a=%h b=%h got=%h exp=%h", o, x, y, {h, l}, exp); end
      checks++; if (dz !== (o[1] && y == 0)) begin errors++; $display("FAIL rand_dz op=%0d b=%h got=%b", o, y, dz); end
      checks++; if (lat !== 33) begin errors++; $display("FAIL rand_latency got=%0d exp=33", lat); end
      checks++; if (held !== 1'b1) begin errors++; $display("FAIL rand_hold got=%b exp=1", held); end
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_back_to_back();
    test_div_signed();
    test_div_zero();
    test_ignore_busy_start();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
